// File: rtl/coin_pulse_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : coin_pulse_seq_if
//  Description : Request/lockout inputs and latch-write/status outputs of the
//                coin counter pulse sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface coin_pulse_seq_if #(
    parameter int PEND_W = 4
);
    logic              INC1;
    logic              INC2;
    logic              LOCK1;
    logic              LOCK2;
    logic [1:0]        CO_ADDR;
    logic              CO_DATA;
    logic              nCOUNTOUT;
    logic [PEND_W-1:0] PEND1;
    logic [PEND_W-1:0] PEND2;
    logic              OVF;
    logic              BUSY;

    modport master (
        output INC1, INC2, LOCK1, LOCK2,
        input  CO_ADDR, CO_DATA, nCOUNTOUT, PEND1, PEND2, OVF, BUSY
    );

    modport slave (
        input  INC1, INC2, LOCK1, LOCK2,
        output CO_ADDR, CO_DATA, nCOUNTOUT, PEND1, PEND2, OVF, BUSY
    );
endinterface
`default_nettype wire

// File: rtl/coin_pulse_seq.sv
`default_nettype none
// ============================================================================
//  Module      : coin_pulse_seq
//  Description : Sequences coin-counter pulses and lockout writes onto a
//                shared addressed latch with a setup/strobe/hold protocol.
//  Revision    : 1.0 - initial release
// ============================================================================
module coin_pulse_seq #(
    parameter int ON_CYC  = 4,
    parameter int OFF_CYC = 4,
    parameter int PEND_W  = 4
) (
    input  wire logic        CLK,
    input  wire logic        nRESET,
    coin_pulse_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP    = 3'd1,
        S_STROBE   = 3'd2,
        S_HOLD     = 3'd3,
        S_ON_WAIT  = 3'd4,
        S_OFF_WAIT = 3'd5
    } state_t;

    localparam logic [15:0]       c_ON_LOAD  = 16'(ON_CYC - 1);
    localparam logic [15:0]       c_OFF_LOAD = 16'(OFF_CYC - 1);
    localparam logic [PEND_W-1:0] c_PEND_MAX = '1;

    state_t            r_state, w_state_nxt;
    logic              r_job_type, w_job_type_nxt;   // 1 = lockout, 0 = counter
    logic              r_job_ch,   w_job_ch_nxt;     // 0 = channel 1
    logic              r_job_data, w_job_data_nxt;
    logic [15:0]       r_timer,    w_timer_nxt;
    logic              r_rr,       w_rr_nxt;
    logic              r_shadow1,  w_shadow1_nxt;
    logic              r_shadow2,  w_shadow2_nxt;
    logic              w_dec1, w_dec2, w_active_nxt;
    logic [PEND_W-1:0] r_pend1, r_pend2;
    logic [PEND_W:0]   w_pend1_nxt, w_pend2_nxt;
    logic              r_ovf, r_busy, r_ncountout, r_co_data;
    logic [1:0]        r_co_addr;

    // Returns {dropped, next_count}; a simultaneous inc and dec cancel out.
    function automatic logic [PEND_W:0] f_pend_nxt(input logic [PEND_W-1:0] cur,
                                                   input logic inc, input logic dec);
        logic              drop;
        logic [PEND_W-1:0] nxt;
        drop = 1'b0;
        nxt  = cur;
        if (inc && !dec) begin
            if (cur == c_PEND_MAX) drop = 1'b1;
            else                   nxt  = cur + 1'b1;
        end else if (dec && !inc) begin
            nxt = cur - 1'b1;
        end
        return {drop, nxt};
    endfunction

    always_comb begin
        w_state_nxt    = r_state;
        w_job_type_nxt = r_job_type;
        w_job_ch_nxt   = r_job_ch;
        w_job_data_nxt = r_job_data;
        w_timer_nxt    = r_timer;
        w_rr_nxt       = r_rr;
        w_shadow1_nxt  = r_shadow1;
        w_shadow2_nxt  = r_shadow2;
        w_dec1         = 1'b0;
        w_dec2         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.LOCK1 != r_shadow1) begin
                    w_job_type_nxt = 1'b1;
                    w_job_ch_nxt   = 1'b0;
                    w_job_data_nxt = bus.LOCK1;
                    w_state_nxt    = S_SETUP;
                end else if (bus.LOCK2 != r_shadow2) begin
                    w_job_type_nxt = 1'b1;
                    w_job_ch_nxt   = 1'b1;
                    w_job_data_nxt = bus.LOCK2;
                    w_state_nxt    = S_SETUP;
                end else if (r_pend1 != '0 || r_pend2 != '0) begin
                    w_job_type_nxt = 1'b0;
                    w_job_data_nxt = 1'b1;
                    w_rr_nxt       = ~r_rr;
                    if (r_pend1 != '0 && r_pend2 != '0) w_job_ch_nxt = r_rr;
                    else                                w_job_ch_nxt = (r_pend1 == '0);
                    w_state_nxt    = S_SETUP;
                end
            end
            S_SETUP:  w_state_nxt = S_STROBE;
            S_STROBE: begin
                w_state_nxt = S_HOLD;
                if (r_job_type) begin
                    if (r_job_ch) w_shadow2_nxt = r_job_data;
                    else          w_shadow1_nxt = r_job_data;
                end else if (r_job_data) begin
                    w_dec1 = ~r_job_ch;
                    w_dec2 = r_job_ch;
                end
            end
            S_HOLD: begin
                if (r_job_type) begin
                    w_state_nxt = S_IDLE;
                end else if (r_job_data) begin
                    w_state_nxt = S_ON_WAIT;
                    w_timer_nxt = c_ON_LOAD;
                end else begin
                    w_state_nxt = S_OFF_WAIT;
                    w_timer_nxt = c_OFF_LOAD;
                end
            end
            S_ON_WAIT: begin
                if (r_timer == 16'd0) begin
                    w_state_nxt    = S_SETUP;
                    w_job_data_nxt = 1'b0;
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
            S_OFF_WAIT: begin
                if (r_timer == 16'd0) w_state_nxt = S_IDLE;
                else                  w_timer_nxt = r_timer - 16'd1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_active_nxt = (w_state_nxt == S_SETUP) || (w_state_nxt == S_STROBE) ||
                          (w_state_nxt == S_HOLD);
    assign w_pend1_nxt  = f_pend_nxt(r_pend1, bus.INC1, w_dec1);
    assign w_pend2_nxt  = f_pend_nxt(r_pend2, bus.INC2, w_dec2);

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            r_state     <= S_IDLE;
            r_job_type  <= 1'b0;
            r_job_ch    <= 1'b0;
            r_job_data  <= 1'b0;
            r_timer     <= 16'd0;
            r_rr        <= 1'b0;
            r_shadow1   <= 1'b0;
            r_shadow2   <= 1'b0;
            r_pend1     <= '0;
            r_pend2     <= '0;
            r_ovf       <= 1'b0;
            r_busy      <= 1'b0;
            r_ncountout <= 1'b1;
            r_co_addr   <= 2'b00;
            r_co_data   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_job_type  <= w_job_type_nxt;
            r_job_ch    <= w_job_ch_nxt;
            r_job_data  <= w_job_data_nxt;
            r_timer     <= w_timer_nxt;
            r_rr        <= w_rr_nxt;
            r_shadow1   <= w_shadow1_nxt;
            r_shadow2   <= w_shadow2_nxt;
            r_pend1     <= w_pend1_nxt[PEND_W-1:0];
            r_pend2     <= w_pend2_nxt[PEND_W-1:0];
            r_ovf       <= r_ovf | w_pend1_nxt[PEND_W] | w_pend2_nxt[PEND_W];
            // Outputs are registered from the next state so the strobe is glitch-free.
            r_busy      <= (w_state_nxt != S_IDLE);
            r_ncountout <= (w_state_nxt != S_STROBE);
            r_co_addr   <= w_active_nxt ? {w_job_type_nxt, w_job_ch_nxt} : 2'b00;
            r_co_data   <= w_active_nxt ? w_job_data_nxt : 1'b0;
        end
    end

    assign bus.CO_ADDR   = r_co_addr;
    assign bus.CO_DATA   = r_co_data;
    assign bus.nCOUNTOUT = r_ncountout;
    assign bus.PEND1     = r_pend1;
    assign bus.PEND2     = r_pend2;
    assign bus.OVF       = r_ovf;
    assign bus.BUSY      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_coin_pulse_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coin_pulse_seq
//  Description : Directed self-checking bench for coin_pulse_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_pulse_seq;

    logic CLK;
    logic nRESET;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   busy_cnt = 0;
    int   q_addr[$];
    int   q_data[$];
    int   q_cyc[$];

    coin_pulse_seq_if #(.PEND_W(4)) bus ();

    coin_pulse_seq #(.ON_CYC(4), .OFF_CYC(4), .PEND_W(4)) u_dut (
        .CLK    (CLK),
        .nRESET (nRESET),
        .bus    (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Strobe log: one entry per low nCOUNTOUT cycle, tagged with its edge count.
    always @(negedge CLK) begin
        if (bus.nCOUNTOUT === 1'b0) begin
            q_addr.push_back(int'(bus.CO_ADDR));
            q_data.push_back(int'(bus.CO_DATA));
            q_cyc.push_back(cyc);
        end
        if (bus.BUSY === 1'b1) busy_cnt = busy_cnt + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        nRESET = 1'b0;
        tick();
        tick();
        nRESET = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int quiet;
        quiet = 0;
        for (int i = 0; i < 400 && quiet < 3; i++) begin
            tick();
            if (bus.BUSY === 1'b0 && bus.PEND1 === 4'd0 && bus.PEND2 === 4'd0) quiet++;
            else quiet = 0;
        end
        chk(tag, 32'(quiet >= 3), 32'd1);
    endtask

    initial begin
        int k, base, b0, n2;
        nRESET = 1'b0;
        bus.INC1 = 1'b0; bus.INC2 = 1'b0; bus.LOCK1 = 1'b0; bus.LOCK2 = 1'b0;
        tick();
        bus.INC1 = 1'b1;
        tick();
        bus.INC1 = 1'b0;
        tick();
        chk("rst_ncount", 32'(bus.nCOUNTOUT), 32'd1);
        chk("rst_addr",   32'(bus.CO_ADDR),   32'd0);
        chk("rst_data",   32'(bus.CO_DATA),   32'd0);
        chk("rst_pend1",  32'(bus.PEND1),     32'd0);
        chk("rst_pend2",  32'(bus.PEND2),     32'd0);
        chk("rst_ovf",    32'(bus.OVF),       32'd0);
        chk("rst_busy",   32'(bus.BUSY),      32'd0);
        nRESET = 1'b1;
        tick();

        // Single count on channel 1
        base = q_addr.size();
        b0 = busy_cnt;
        bus.INC1 = 1'b1;
        tick();
        bus.INC1 = 1'b0;
        k = cyc;
        chk("one_pend_up", 32'(bus.PEND1), 32'd1);
        chk("one_idle",    32'(bus.BUSY),  32'd0);
        tick();
        chk("one_setup_busy",  32'(bus.BUSY),      32'd1);
        chk("one_setup_ncnt",  32'(bus.nCOUNTOUT), 32'd1);
        chk("one_setup_addr",  32'(bus.CO_ADDR),   32'd0);
        chk("one_setup_data",  32'(bus.CO_DATA),   32'd1);
        tick();
        chk("one_strobe_ncnt", 32'(bus.nCOUNTOUT), 32'd0);
        chk("one_strobe_pend", 32'(bus.PEND1),     32'd1);
        tick();
        chk("one_hold_ncnt",   32'(bus.nCOUNTOUT), 32'd1);
        chk("one_hold_data",   32'(bus.CO_DATA),   32'd1);
        chk("one_pend_down",   32'(bus.PEND1),     32'd0);
        wait_idle("one_timeout");
        chk("one_nstrobes",  32'(q_addr.size() - base), 32'd2);
        chk("one_set_lat",   32'(q_cyc[base] - k), 32'd2);
        chk("one_set_addr",  32'(q_addr[base]), 32'd0);
        chk("one_set_data",  32'(q_data[base]), 32'd1);
        chk("one_clr_gap",   32'(q_cyc[base+1] - q_cyc[base]), 32'd7);
        chk("one_clr_addr",  32'(q_addr[base+1]), 32'd0);
        chk("one_clr_data",  32'(q_data[base+1]), 32'd0);
        chk("one_busy_len",  32'(busy_cnt - b0), 32'd14);

        // Round-robin with two counts queued on each channel
        do_reset();
        base = q_addr.size();
        bus.INC1 = 1'b1; bus.INC2 = 1'b1;
        tick();
        tick();
        bus.INC1 = 1'b0; bus.INC2 = 1'b0;
        chk("rr_pend1", 32'(bus.PEND1), 32'd2);
        chk("rr_pend2", 32'(bus.PEND2), 32'd2);
        wait_idle("rr_timeout");
        chk("rr_nstrobes", 32'(q_addr.size() - base), 32'd8);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_addr%0d", i), 32'(q_addr[base+2*i]), 32'(i % 2));
            chk($sformatf("rr_data%0d", i), 32'(q_data[base+2*i]), 32'd1);
            if (i > 0)
                chk($sformatf("rr_gap%0d", i),
                    32'(q_cyc[base+2*i] - q_cyc[base+2*i-2]), 32'd15);
        end

        // Saturation on channel 2 while a channel-1 job runs
        do_reset();
        bus.INC1 = 1'b1;
        tick();
        bus.INC1 = 1'b0;
        bus.INC2 = 1'b1;
        repeat (15) tick();
        bus.INC2 = 1'b0;
        chk("sat_pend15", 32'(bus.PEND2), 32'd15);
        chk("sat_no_ovf", 32'(bus.OVF),   32'd0);
        tick();
        chk("sat_setup_addr", 32'(bus.CO_ADDR), 32'd1);
        tick();
        chk("sat_strobe",      32'(bus.nCOUNTOUT), 32'd0);
        bus.INC2 = 1'b1;
        tick();
        chk("sat_incdec_pend", 32'(bus.PEND2), 32'd15);
        chk("sat_incdec_ovf",  32'(bus.OVF),   32'd0);
        tick();
        bus.INC2 = 1'b0;
        chk("sat_drop_pend",   32'(bus.PEND2), 32'd15);
        chk("sat_drop_ovf",    32'(bus.OVF),   32'd1);
        tick();
        chk("sat_ovf_sticky",  32'(bus.OVF),   32'd1);
        do_reset();
        chk("sat_rst_pend",    32'(bus.PEND2), 32'd0);
        chk("sat_rst_ovf",     32'(bus.OVF),   32'd0);

        // Lockout raised mid-pulse waits for the counter job to finish
        base = q_addr.size();
        bus.INC1 = 1'b1;
        tick();
        k = cyc;
        bus.INC1 = 1'b0;
        bus.INC2 = 1'b1;
        tick();
        bus.INC2 = 1'b0;
        repeat (3) tick();
        chk("lk_onwait_busy", 32'(bus.BUSY),      32'd1);
        chk("lk_onwait_ncnt", 32'(bus.nCOUNTOUT), 32'd1);
        chk("lk_onwait_addr", 32'(bus.CO_ADDR),   32'd0);
        chk("lk_onwait_data", 32'(bus.CO_DATA),   32'd0);
        bus.LOCK2 = 1'b1;
        wait_idle("lk_timeout");
        chk("lk_nstrobes", 32'(q_addr.size() - base), 32'd5);
        chk("lk_a0", 32'(q_addr[base]),   32'd0); chk("lk_d0", 32'(q_data[base]),   32'd1);
        chk("lk_a1", 32'(q_addr[base+1]), 32'd0); chk("lk_d1", 32'(q_data[base+1]), 32'd0);
        chk("lk_a2", 32'(q_addr[base+2]), 32'd3); chk("lk_d2", 32'(q_data[base+2]), 32'd1);
        chk("lk_a3", 32'(q_addr[base+3]), 32'd1); chk("lk_d3", 32'(q_data[base+3]), 32'd1);
        chk("lk_a4", 32'(q_addr[base+4]), 32'd1); chk("lk_d4", 32'(q_data[base+4]), 32'd0);
        chk("lk_write_cyc", 32'(q_cyc[base+2] - k), 32'd17);

        // LOCK1 glitch during OFF_WAIT returns to its shadow before IDLE
        base = q_addr.size();
        bus.INC1 = 1'b1;
        tick();
        bus.INC1 = 1'b0;
        repeat (10) tick();
        chk("gl_offwait_busy", 32'(bus.BUSY),      32'd1);
        chk("gl_offwait_ncnt", 32'(bus.nCOUNTOUT), 32'd1);
        bus.LOCK1 = 1'b1;
        tick();
        tick();
        bus.LOCK1 = 1'b0;
        wait_idle("gl_timeout");
        chk("gl_nstrobes", 32'(q_addr.size() - base), 32'd2);
        n2 = 0;
        for (int i = base; i < q_addr.size(); i++) if (q_addr[i] == 2) n2++;
        chk("gl_no_lock1", 32'(n2), 32'd0);
        base = q_addr.size();
        bus.LOCK1 = 1'b1;
        wait_idle("gl_set_timeout");
        chk("gl_set_n",    32'(q_addr.size() - base), 32'd1);
        chk("gl_set_addr", 32'(q_addr[base]), 32'd2);
        chk("gl_set_data", 32'(q_data[base]), 32'd1);
        base = q_addr.size();
        bus.LOCK1 = 1'b0;
        bus.LOCK2 = 1'b0;
        wait_idle("gl_clr_timeout");
        chk("gl_clr_n",    32'(q_addr.size() - base), 32'd2);
        chk("gl_clr_a0",   32'(q_addr[base]),   32'd2);
        chk("gl_clr_d0",   32'(q_data[base]),   32'd0);
        chk("gl_clr_a1",   32'(q_addr[base+1]), 32'd3);
        chk("gl_clr_d1",   32'(q_data[base+1]), 32'd0);

        // Reset during ON_WAIT abandons the job silently
        bus.INC1 = 1'b1; bus.INC2 = 1'b1;
        tick();
        bus.INC1 = 1'b0; bus.INC2 = 1'b0;
        repeat (5) tick();
        chk("mr_onwait_busy", 32'(bus.BUSY), 32'd1);
        nRESET = 1'b0;
        tick();
        chk("mr_ncnt",  32'(bus.nCOUNTOUT), 32'd1);
        chk("mr_pend1", 32'(bus.PEND1),     32'd0);
        chk("mr_pend2", 32'(bus.PEND2),     32'd0);
        chk("mr_busy",  32'(bus.BUSY),      32'd0);
        chk("mr_addr",  32'(bus.CO_ADDR),   32'd0);
        nRESET = 1'b1;
        base = q_addr.size();
        repeat (30) tick();
        chk("mr_quiet", 32'(q_addr.size() - base), 32'd0);
        bus.INC2 = 1'b1;
        tick();
        bus.INC2 = 1'b0;
        wait_idle("mr_timeout");
        chk("mr_new_n",    32'(q_addr.size() - base), 32'd2);
        chk("mr_new_addr", 32'(q_addr[base]), 32'd1);
        chk("mr_new_data", 32'(q_data[base]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
